// File: rtl/goldschmidt_pkg.sv
// Shared types and constants for the Goldschmidt divider sequencer and datapath.
// Contents: FSM state encoding, mode/stage select encodings, k0 seed, and
// helpers that map an FSM state to its datapath selects.
package goldschmidt_pkg;

  localparam int unsigned GS_STATE_W = 3;
  localparam int unsigned GS_WIDTH   = 29;
  localparam int unsigned GS_FRAC_W  = 26;

  typedef enum logic [GS_STATE_W-1:0] {
    GS_IDLE    = 3'd0,
    GS_INIT_N  = 3'd1,
    GS_INIT_D  = 3'd2,
    GS_ITER_N  = 3'd3,
    GS_ITER_D  = 3'd4,
    GS_CAPTURE = 3'd5,
    GS_VALID   = 3'd6
  } gs_state_t;

  // Datapath selects: mode picks k0 seeding vs refinement, stage picks N vs D/K update.
  localparam logic MODE_INIT = 1'b0;
  localparam logic MODE_ITER = 1'b1;
  localparam logic STAGE_N   = 1'b0;
  localparam logic STAGE_D   = 1'b1;

  // Initial reciprocal estimate 0.75 with GS_FRAC_W fractional bits.
  localparam logic [GS_WIDTH-1:0] K0_INIT = 29'h0300_0000;

  // Only the two INIT states seed with k0.
  function automatic logic gs_mode(input gs_state_t s);
    return ((s == GS_INIT_N) || (s == GS_INIT_D)) ? MODE_INIT : MODE_ITER;
  endfunction

  // N updates only in INIT_N/ITER_N so the quotient register is frozen otherwise.
  function automatic logic gs_stage(input gs_state_t s);
    return ((s == GS_INIT_N) || (s == GS_ITER_N)) ? STAGE_N : STAGE_D;
  endfunction

endpackage

// File: rtl/goldschmidt_seq_iter_counter.sv
// gs_iter_counter: refinement iteration counter for the Goldschmidt sequencer.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clear_i      synchronous clear (takes priority over inc_i)
//   inc_i        increment by one
//   last_c_o     combinational terminal count, high when count == ITERS-1
module gs_iter_counter #(
  parameter int unsigned ITERS = 4,
  parameter int unsigned CNT_W = $clog2(ITERS + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic last_c_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count; reaches at most ITERS, which CNT_W always holds.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_c_o = (cnt_q == CNT_W'(ITERS - 1));

endmodule

// File: rtl/goldschmidt_seq.sv
// goldschmidt_seq: handshaked sequencer for the Goldschmidt divider datapath.
// Accepts one request at a time, holds the operands, steps the datapath
// mode/stage selects through ITERS refinement iterations, then captures the
// quotient and offers it on a valid/ready output.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   start / ready                 request handshake (accept on start && ready)
//   numerator_in, denominator_in  operands, sampled on acceptance
//   dp_numerator, dp_denominator  held operands to the datapath
//   mode, stage                   datapath selects
//   dp_quotient                   datapath N register
//   out_valid / out_ready         result handshake
//   quotient_out, div_by_zero     result payload
// Build option: GOLDSCHMIDT_DIVZERO_EN short-circuits a zero divisor straight
// to VALID with an all-ones quotient and div_by_zero set.
module goldschmidt_seq
  import goldschmidt_pkg::*;
#(
  parameter int unsigned WIDTH = 29,
  parameter int unsigned ITERS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] numerator_in,
  input  logic [WIDTH-1:0] denominator_in,
  output logic [WIDTH-1:0] dp_numerator,
  output logic [WIDTH-1:0] dp_denominator,
  output logic             mode,
  output logic             stage,
  input  logic [WIDTH-1:0] dp_quotient,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient_out,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(ITERS + 1);

  gs_state_t        state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             mode_q, mode_d;
  logic             stage_q, stage_d;
`ifdef GOLDSCHMIDT_DIVZERO_EN
  logic             dbz_q, dbz_d;
`endif

  logic             accept_c;
  logic             cnt_clr_c;
  logic             cnt_inc_c;
  logic             iter_last_c;

  gs_iter_counter #(
    .ITERS (ITERS),
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (cnt_clr_c),
    .inc_i    (cnt_inc_c),
    .last_c_o (iter_last_c)
  );

  assign accept_c = start && ready_q;

  // Next state and next register values; output flags are decoded from the
  // next state so every handshake/select output comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    den_d     = den_q;
    quot_d    = quot_q;
    cnt_clr_c = 1'b0;
    cnt_inc_c = 1'b0;
`ifdef GOLDSCHMIDT_DIVZERO_EN
    dbz_d     = dbz_q;
`endif

    case (state_q)
      GS_IDLE: begin
        if (accept_c) begin
          num_d     = numerator_in;
          den_d     = denominator_in;
          cnt_clr_c = 1'b1;
          state_d   = GS_INIT_N;
`ifdef GOLDSCHMIDT_DIVZERO_EN
          dbz_d     = 1'b0;
          if (denominator_in == '0) begin
            quot_d  = '1;
            dbz_d   = 1'b1;
            state_d = GS_VALID;
          end
`endif
        end
      end
      GS_INIT_N:  state_d = GS_INIT_D;
      GS_INIT_D:  state_d = GS_ITER_N;
      GS_ITER_N: begin
        // The last N update goes straight to capture; its D update is unused.
        cnt_inc_c = 1'b1;
        state_d   = iter_last_c ? GS_CAPTURE : GS_ITER_D;
      end
      GS_ITER_D:  state_d = GS_ITER_N;
      GS_CAPTURE: begin
        quot_d  = dp_quotient;
        state_d = GS_VALID;
      end
      GS_VALID: begin
        if (out_ready) begin
          state_d = GS_IDLE;
        end
      end
      default:    state_d = GS_IDLE;
    endcase

    ready_d = (state_d == GS_IDLE);
    valid_d = (state_d == GS_VALID);
    mode_d  = gs_mode(state_d);
    stage_d = gs_stage(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= GS_IDLE;
      num_q   <= '0;
      den_q   <= '0;
      quot_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      mode_q  <= MODE_ITER;
      stage_q <= STAGE_D;
`ifdef GOLDSCHMIDT_DIVZERO_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      quot_q  <= quot_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
      stage_q <= stage_d;
`ifdef GOLDSCHMIDT_DIVZERO_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign ready          = ready_q;
  assign out_valid      = valid_q;
  assign mode           = mode_q;
  assign stage          = stage_q;
  assign dp_numerator   = num_q;
  assign dp_denominator = den_q;
  assign quotient_out   = quot_q;
`ifdef GOLDSCHMIDT_DIVZERO_EN
  assign div_by_zero    = dbz_q;
`else
  assign div_by_zero    = 1'b0;
`endif

endmodule
